// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS/CTRL bit indices and FSM state types for uart_mmio
package uart_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;
  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_TX_FULL = 2;
  localparam int ST_TX_IDLE = 3;
  localparam int ST_OVERRUN = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int CT_RX_IRQ = 0;
  localparam int CT_TX_IRQ = 1;
  localparam int CT_LOOPBACK = 2;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO (push/wdata in, pop/rdata out, full/empty/count flags, async reset)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART (addr/wr_en/rd_en/wdata/rdata bus, rx_serial/tx_serial line, irq) with FIFOs and baud divisor
module uart_mmio import uart_pkg::*; #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          OVERSAMPLE = 16,
  parameter logic [15:0] DIV_RESET = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        rx_serial,
  output logic        tx_serial,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  logic [15:0] div, tick_cnt, status;
  logic [2:0] ctrl, rx_bits, tx_bits;
  logic [7:0] rx_head, tx_head, rx_shift, tx_shift;
  logic [AW:0] rx_count, tx_count;
  logic [SW-1:0] rx_cnt, tx_cnt;
  logic overrun, frame_err, tick, wr_data, wr_status, wr_div, wr_ctrl;
  logic rx_s1, rx_s2, rx_prev, rx_line, rx_fall, rx_mid, rx_push, rx_pop, rx_ovr, rx_ferr;
  logic rx_full, rx_empty, tx_full, tx_empty, tx_push, tx_pop, tx_end, tx_bit, tx_idle;
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;
  assign wr_data = wr_en & (addr == ADDR_DATA);
  assign wr_status = wr_en & (addr == ADDR_STATUS);
  assign wr_div = wr_en & (addr == ADDR_DIV);
  assign wr_ctrl = wr_en & (addr == ADDR_CTRL);
  assign tick = tick_cnt == div;
  assign rx_line = ctrl[CT_LOOPBACK] ? tx_serial : rx_s2;
  assign rx_fall = rx_prev & ~rx_line;
  assign rx_mid = tick & (rx_cnt == (rx_state == RX_START ? HALF : LAST));
  assign rx_pop = rd_en & (addr == ADDR_DATA);
  assign tx_end = tick & (tx_cnt == LAST);
  assign tx_push = wr_data & ~tx_full;
  assign tx_idle = tx_count == '0 && tx_state == TX_IDLE;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift), .pop(rx_pop),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(wdata[7:0]), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  always_comb begin
    status = '0;
    status[ST_RX_NONEMPTY] = rx_count != '0;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_OVERRUN] = overrun;
    status[ST_FRAME_ERR] = frame_err;
  end
  assign rdata = addr == ADDR_DATA ? {8'h00, rx_empty ? 8'h00 : rx_head} :
                 addr == ADDR_STATUS ? status : addr == ADDR_DIV ? div : {13'h0000, ctrl};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div <= DIV_RESET;
      ctrl <= '0;
      tick_cnt <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      irq <= 1'b0;
      tx_serial <= 1'b1;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      div <= wr_div ? wdata : div;
      ctrl <= wr_ctrl ? wdata[2:0] : ctrl;
      tick_cnt <= wr_div || tick ? '0 : tick_cnt + 16'd1;
      overrun <= rx_ovr | overrun & ~(wr_status & wdata[ST_OVERRUN]);
      frame_err <= rx_ferr | frame_err & ~(wr_status & wdata[ST_FRAME_ERR]);
      irq <= ctrl[CT_RX_IRQ] & status[ST_RX_NONEMPTY] | ctrl[CT_TX_IRQ] & tx_idle | overrun | frame_err;
      tx_serial <= tx_bit;
      rx_s1 <= rx_serial;
      rx_s2 <= rx_s1;
      rx_prev <= rx_line;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_state <= RX_IDLE;
    else rx_state <= rx_next;
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  rx_next = rx_fall ? RX_START : RX_IDLE;
      RX_START: rx_next = rx_mid ? (rx_line ? RX_IDLE : RX_DATA) : RX_START;
      RX_DATA:  rx_next = rx_mid && rx_bits == 3'd7 ? RX_STOP : RX_DATA;
      RX_STOP:  rx_next = rx_mid ? RX_IDLE : RX_STOP;
      default:  rx_next = RX_IDLE;
    endcase
  end
  always_comb begin
    rx_push = rx_state == RX_STOP && rx_mid && rx_line;
    rx_ferr = rx_state == RX_STOP && rx_mid && !rx_line;
    rx_ovr = rx_push & rx_full & ~rx_pop;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) tx_state <= TX_IDLE;
    else tx_state <= tx_next;
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  tx_next = tx_empty ? TX_IDLE : TX_START;
      TX_START: tx_next = tx_end ? TX_DATA : TX_START;
      TX_DATA:  tx_next = tx_end && tx_bits == 3'd7 ? TX_STOP : TX_DATA;
      TX_STOP:  tx_next = tx_end ? (tx_empty ? TX_IDLE : TX_START) : TX_STOP;
      default:  tx_next = TX_IDLE;
    endcase
  end
  always_comb begin
    tx_pop = !tx_empty && (tx_state == TX_IDLE || tx_state == TX_STOP && tx_end);
    tx_bit = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_shift[0] : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_cnt <= '0;
      rx_bits <= '0;
      rx_shift <= '0;
      tx_cnt <= '0;
      tx_bits <= '0;
      tx_shift <= '0;
    end else begin
      rx_cnt <= rx_state == RX_IDLE || rx_mid ? '0 : rx_cnt + SW'(tick);
      rx_bits <= rx_state != RX_DATA ? '0 : rx_bits + 3'(rx_mid);
      rx_shift <= rx_state == RX_DATA && rx_mid ? {rx_line, rx_shift[7:1]} : rx_shift;
      tx_cnt <= tx_state == TX_IDLE || tx_end ? '0 : tx_cnt + SW'(tick);
      tx_bits <= tx_state != TX_DATA ? '0 : tx_bits + 3'(tx_end);
      tx_shift <= tx_pop ? tx_head : tx_state == TX_DATA && tx_end ? tx_shift >> 1 : tx_shift;
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: randomized self-checking bench for uart_mmio against a queue-based UART model
module tb_uart_mmio;
  import uart_pkg::*;
  logic clk, rst, wr_en, rd_en, rx_serial, tx_serial, irq;
  logic [1:0] addr;
  logic [15:0] wdata, rdata, v;
  logic [7:0] b;
  logic [9:0] fr;
  logic s [160];
  logic [7:0] tx_got [$], exp_tx [$], exp_rx [$];
  logic [7:0] mon_sh;
  logic mon_busy;
  int mon_cnt, n, vectors, miscompares;
  uart_mmio u_dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
    .rdata(rdata), .rx_serial(rx_serial), .tx_serial(tx_serial), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a;
    wdata = d;
    wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, input logic pop, output logic [15:0] d);
    addr = a;
    rd_en = pop;
    #1 d = rdata;
    cyc(1);
    rd_en = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_serial = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      cyc(16);
    end
    rx_serial = stop;
    cyc(16);
    rx_serial = 1'b1;
    cyc(4);
  endtask
  initial begin
    mon_busy = 1'b0;
    mon_cnt = 0;
    mon_sh = '0;
    forever begin
      @(negedge clk);
      if (rst) mon_busy = 1'b0;
      else if (!mon_busy) begin
        if (!tx_serial) begin
          mon_busy = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt - 8) % 16 == 0) mon_sh = {tx_serial, mon_sh[7:1]};
        if (mon_cnt == 152) begin
          check("tx_stop_bit", 16'(tx_serial), 16'd1);
          tx_got.push_back(mon_sh);
          mon_busy = 1'b0;
        end
      end
    end
  end
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    addr = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    rx_serial = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    rd(ADDR_STATUS, 1'b0, v); check("rst_status", v, 16'h0008);
    rd(ADDR_DIV, 1'b0, v); check("rst_div", v, 16'd325);
    rd(ADDR_CTRL, 1'b0, v); check("rst_ctrl", v, 16'h0000);
    rd(ADDR_DATA, 1'b1, v); check("rst_data", v, 16'h0000);
    check("rst_irq", 16'(irq), 16'd0);
    check("rst_tx", 16'(tx_serial), 16'd1);
    wr(ADDR_DIV, 16'h0000);
    rd(ADDR_DIV, 1'b0, v); check("div_rd", v, 16'h0000);
    wr(ADDR_DATA, 16'h00A5);
    n = 0;
    while (tx_serial && n < 8) begin
      cyc(1);
      n++;
    end
    check("tx_start_lat", 16'(n >= 1 && n <= 2), 16'd1);
    for (int i = 0; i < 160; i++) begin
      s[i] = tx_serial;
      cyc(1);
    end
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check("tx_bit_head", 16'(s[16*i]), 16'(fr[i]));
      check("tx_bit_tail", 16'(s[16*i+15]), 16'(fr[i]));
    end
    cyc(2);
    rd(ADDR_STATUS, 1'b0, v); check("tx_done_status", v, 16'h0008);
    check("tx_mon_count", 16'(tx_got.size()), 16'd1);
    if (tx_got.size() > 0) check("tx_mon_byte", {8'h00, tx_got[0]}, 16'h00A5);
    wr(ADDR_CTRL, 16'h0005);
    wr(ADDR_DATA, 16'h003C);
    n = 0;
    while (!irq && n < 400) begin
      cyc(1);
      n++;
    end
    check("lb_irq", 16'(irq), 16'd1);
    check("lb_latency", 16'(n >= 140 && n <= 180), 16'd1);
    rd(ADDR_STATUS, 1'b0, v); check("lb_nonempty", v & 16'h0001, 16'h0001);
    rd(ADDR_DATA, 1'b1, v); check("lb_data", v, 16'h003C);
    cyc(2);
    check("lb_irq_fall", 16'(irq), 16'd0);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      wr(ADDR_DATA, {8'h00, b});
      n = 0;
      while (!irq && n < 400) begin
        cyc(1);
        n++;
      end
      rd(ADDR_DATA, 1'b1, v); check("lb_rand", v, {8'h00, b});
    end
    cyc(20);
    wr(ADDR_CTRL, 16'h0002);
    cyc(2);
    check("tx_irq_on", 16'(irq), 16'd1);
    wr(ADDR_CTRL, 16'h0000);
    cyc(2);
    check("tx_irq_off", 16'(irq), 16'd0);
    exp_rx.delete();
    for (int k = 0; k <= 16; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      if (exp_rx.size() < 16) exp_rx.push_back(b);
    end
    rd(ADDR_STATUS, 1'b0, v); check("ovr_status", v, 16'h001B);
    check("ovr_irq", 16'(irq), 16'd1);
    wr(ADDR_STATUS, 16'h0010);
    rd(ADDR_STATUS, 1'b0, v); check("ovr_clear", v, 16'h000B);
    for (int k = 0; k < 16; k++) begin
      rd(ADDR_DATA, 1'b1, v); check("rx_byte", v, {8'h00, exp_rx[k]});
    end
    rd(ADDR_STATUS, 1'b0, v); check("rx_drained", v, 16'h0008);
    send_frame(8'($urandom), 1'b0);
    rd(ADDR_STATUS, 1'b0, v); check("ferr_status", v, 16'h0028);
    check("ferr_irq", 16'(irq), 16'd1);
    wr(ADDR_STATUS, 16'h0020);
    rd(ADDR_STATUS, 1'b0, v); check("ferr_clear", v, 16'h0008);
    rx_serial = 1'b0;
    cyc(8);
    rx_serial = 1'b1;
    cyc(40);
    rd(ADDR_STATUS, 1'b0, v); check("glitch_status", v, 16'h0008);
    tx_got.delete();
    exp_tx.delete();
    b = 8'($urandom);
    wr(ADDR_DATA, {8'h00, b});
    exp_tx.push_back(b);
    cyc(4);
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom);
      wr(ADDR_DATA, {8'h00, b});
      if (k < 16) exp_tx.push_back(b);
    end
    rd(ADDR_STATUS, 1'b0, v); check("tx_full", v & 16'h0004, 16'h0004);
    n = 0;
    while (tx_got.size() < 17 && n < 4000) begin
      cyc(1);
      n++;
    end
    cyc(400);
    check("tx_stream_len", 16'(tx_got.size()), 16'd17);
    for (int k = 0; k < exp_tx.size(); k++)
      check("tx_stream_byte", k < tx_got.size() ? {8'h00, tx_got[k]} : 16'hFFFF, {8'h00, exp_tx[k]});
    rd(ADDR_STATUS, 1'b0, v); check("tx_drained", v, 16'h0008);
    wr(ADDR_DATA, 16'h0000);
    cyc(40);
    check("pre_rst_tx", 16'(tx_serial), 16'd0);
    rst = 1'b1;
    #1 check("async_rst_tx", 16'(tx_serial), 16'd1);
    rd(ADDR_STATUS, 1'b0, v); check("mid_rst_status", v, 16'h0008);
    rd(ADDR_DIV, 1'b0, v); check("mid_rst_div", v, 16'd325);
    check("mid_rst_irq", 16'(irq), 16'd0);
    rst = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
